mesh_term_adapter: RTL

- Parametrised terminal-side buffering adapter for the mesh generator's pending/pop terminal interface.
- Sits between the per-terminal host side (agents or an upstream block) and the mesh `NTERM = ROWS*COLUMS` terminal ports.
- Each terminal gets an ingress FIFO (host to mesh) and an egress FIFO (mesh to host).
- Tracks occupancy and keeps sticky overflow/underflow flags per terminal.

---
 rtl/mesh_adapter_pkg.sv | 21 ++
 rtl/mesh_term_adapter_term_fifo.sv | 93 +++++++++
 rtl/mesh_term_adapter.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/mesh_adapter_pkg.sv
// Shared definitions for the mesh terminal adapter slice.
//
// Contents:
//   DEF_ROWS, DEF_COLUMS, DEF_PCKG_SZ, DEF_FIFO_DEPTH - default geometry,
//     matching the mesh generator's existing macro values.
//   pkt_t  - one packet at the default width.
//   nterm  - number of terminals for a given mesh geometry.
package mesh_adapter_pkg;

    localparam int unsigned DEF_ROWS       = 4;
    localparam int unsigned DEF_COLUMS     = 4;
    localparam int unsigned DEF_PCKG_SZ    = 40;
    localparam int unsigned DEF_FIFO_DEPTH = 4;

    typedef logic [DEF_PCKG_SZ-1:0] pkt_t;

    function automatic int unsigned nterm(input int unsigned rows, input int unsigned colums);
        return rows * colums;
    endfunction

endpackage

// File: rtl/mesh_term_adapter_term_fifo.sv
// term_fifo: first-word-fall-through FIFO for one terminal direction.
//
// Ports:
//   clk, reset - rising-edge clock, synchronous active-low reset
//   push, din  - write request and data
//   pop        - read request
//   dout       - head entry, forced to 0 while empty
//   full/empty - registered-state status
//   occ        - current number of entries (0..DEPTH)
//   ovf        - pulse: push refused because full and no pop this cycle
//   udf        - pulse: pop requested while empty
//
// A push on a full FIFO is taken when a pop drains the head in the same
// cycle. DEPTH need not be a power of two; pointers wrap explicitly.
import mesh_adapter_pkg::*;

module term_fifo #(
    parameter  int unsigned DEPTH = DEF_FIFO_DEPTH,
    parameter  int unsigned W     = DEF_PCKG_SZ,
    localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] occ,
    output logic          ovf,
    output logic          udf
);

    localparam int unsigned   PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST     = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_OCC = CW'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] occ_q, occ_d;
    logic          push_ok, pop_ok;

    assign full  = (occ_q == FULL_OCC);
    assign empty = (occ_q == '0);
    assign occ   = occ_q;
    assign dout  = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        pop_ok  = pop && !empty;
        push_ok = push && (!full || pop_ok);
        ovf     = push && full && !pop;
        udf     = pop && empty;

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;

        if (push_ok) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + PW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + PW'(1);
        end
        if (push_ok && !pop_ok) begin
            occ_d = occ_q + CW'(1);
        end else if (!push_ok && pop_ok) begin
            occ_d = occ_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    // Storage is not reset: emptiness comes from the pointers/occupancy.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/mesh_term_adapter.sv
// mesh_term_adapter: per-terminal buffering between host agents and the
// mesh pending/pop terminal interface.
//
// Each of the NTERM = ROWS*COLUMS terminals owns an ingress FIFO
// (host -> mesh) and an egress FIFO (mesh -> host). Terminals are fully
// independent.
//
// Ports (per terminal i, packet slice [i*pckg_sz +: pckg_sz]):
//   clk, reset           - rising-edge clock, synchronous active-low reset
//   h_push, h_data_in    - host write into ingress FIFO
//   h_full               - ingress FIFO full
//   pndng_i_in           - ingress FIFO non-empty, seen by the mesh
//   data_out_i_in        - ingress head (0 when empty)
//   popin                - mesh consumes ingress head
//   pndng, data_out      - mesh offers an output packet
//   pop                  - adapter takes the mesh packet (combinational)
//   h_pndng, h_data_out  - egress FIFO non-empty / head (0 when empty)
//   h_pop                - host consumes egress head
//   occ_in, occ_out      - ingress / egress occupancy, CW bits each
//   ovf, udf             - sticky overflow / underflow flags
//   err_clr              - clears sticky flags; a new set wins
//
// Optional feature, macro ADAPTER_PKT_CNT_EN: adds cnt_in / cnt_out
// (32 bits per terminal) counting packets taken by the mesh and packets
// delivered to the host. They wrap, reset to 0 and clear on err_clr.
import mesh_adapter_pkg::*;

module mesh_term_adapter #(
    parameter  int unsigned ROWS       = DEF_ROWS,
    parameter  int unsigned COLUMS     = DEF_COLUMS,
    parameter  int unsigned pckg_sz    = DEF_PCKG_SZ,
    parameter  int unsigned fifo_depth = DEF_FIFO_DEPTH,
    localparam int unsigned NTERM      = nterm(ROWS, COLUMS),
    localparam int unsigned CW         = $clog2(fifo_depth + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NTERM-1:0]         h_push,
    input  logic [NTERM*pckg_sz-1:0] h_data_in,
    output logic [NTERM-1:0]         h_full,
    output logic [NTERM-1:0]         pndng_i_in,
    output logic [NTERM*pckg_sz-1:0] data_out_i_in,
    input  logic [NTERM-1:0]         popin,
    input  logic [NTERM-1:0]         pndng,
    input  logic [NTERM*pckg_sz-1:0] data_out,
    output logic [NTERM-1:0]         pop,
    output logic [NTERM-1:0]         h_pndng,
    output logic [NTERM*pckg_sz-1:0] h_data_out,
    input  logic [NTERM-1:0]         h_pop,
    output logic [NTERM*CW-1:0]      occ_in,
    output logic [NTERM*CW-1:0]      occ_out,
    output logic [NTERM-1:0]         ovf,
    output logic [NTERM-1:0]         udf,
    input  logic                     err_clr
`ifdef ADAPTER_PKT_CNT_EN
    ,
    output logic [NTERM*32-1:0]      cnt_in,
    output logic [NTERM*32-1:0]      cnt_out
`endif
);

    logic [NTERM-1:0] ovf_set, udf_set;
    logic [NTERM-1:0] ovf_q, ovf_d;
    logic [NTERM-1:0] udf_q, udf_d;
    logic [NTERM-1:0] ing_empty, egr_empty;

    for (genvar i = 0; i < NTERM; i++) begin : g_term
        logic ing_full, egr_full;
        logic ing_ovf, ing_udf, egr_ovf, egr_udf;
        logic egr_push;

        term_fifo #(
            .DEPTH (fifo_depth),
            .W     (pckg_sz)
        ) u_ing (
            .clk   (clk),
            .reset (reset),
            .push  (h_push[i]),
            .din   (h_data_in[i*pckg_sz +: pckg_sz]),
            .pop   (popin[i]),
            .dout  (data_out_i_in[i*pckg_sz +: pckg_sz]),
            .full  (ing_full),
            .empty (ing_empty[i]),
            .occ   (occ_in[i*CW +: CW]),
            .ovf   (ing_ovf),
            .udf   (ing_udf)
        );

        // Mesh handshake: take the packet when there is room or the host
        // frees a slot this very cycle (h_pop -> pop is combinational).
        assign egr_push = pndng[i] && (!egr_full || h_pop[i]);
        assign pop[i]   = egr_push;

        term_fifo #(
            .DEPTH (fifo_depth),
            .W     (pckg_sz)
        ) u_egr (
            .clk   (clk),
            .reset (reset),
            .push  (egr_push),
            .din   (data_out[i*pckg_sz +: pckg_sz]),
            .pop   (h_pop[i]),
            .dout  (h_data_out[i*pckg_sz +: pckg_sz]),
            .full  (egr_full),
            .empty (egr_empty[i]),
            .occ   (occ_out[i*CW +: CW]),
            .ovf   (egr_ovf),
            .udf   (egr_udf)
        );

        assign h_full[i]     = ing_full;
        assign pndng_i_in[i] = !ing_empty[i];
        assign h_pndng[i]    = !egr_empty[i];
        assign ovf_set[i]    = ing_ovf || egr_ovf;
        assign udf_set[i]    = ing_udf || egr_udf;
    end

    always_comb begin
        ovf_d = ovf_set | (ovf_q & ~{NTERM{err_clr}});
        udf_d = udf_set | (udf_q & ~{NTERM{err_clr}});
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ovf_q <= '0;
            udf_q <= '0;
        end else begin
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign ovf = ovf_q;
    assign udf = udf_q;

`ifdef ADAPTER_PKT_CNT_EN
    logic [31:0] cnt_in_q  [NTERM];
    logic [31:0] cnt_in_d  [NTERM];
    logic [31:0] cnt_out_q [NTERM];
    logic [31:0] cnt_out_d [NTERM];

    always_comb begin
        cnt_in  = '0;
        cnt_out = '0;
        for (int unsigned i = 0; i < NTERM; i++) begin
            cnt_in_d[i]  = err_clr ? '0 : cnt_in_q[i]  + 32'(popin[i] && !ing_empty[i]);
            cnt_out_d[i] = err_clr ? '0 : cnt_out_q[i] + 32'(h_pop[i] && !egr_empty[i]);
            cnt_in[i*32 +: 32]  = cnt_in_q[i];
            cnt_out[i*32 +: 32] = cnt_out_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_in_q  <= '{default: '0};
            cnt_out_q <= '{default: '0};
        end else begin
            cnt_in_q  <= cnt_in_d;
            cnt_out_q <= cnt_out_d;
        end
    end
`endif

endmodule
